// File: rtl/multi_port_memory_if.sv
// Request/response bundle for multi_port_memory.
// Per-port fields are packed, port i at slice i.
interface multi_port_memory_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_SIZE  = 8,
  parameter int LANES      = 4,
  parameter int NUM_PORTS  = 2
);
  localparam int DATA_LEN = LANES * BYTE_SIZE;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_LEN-1:0]   req_wdata;
  logic [NUM_PORTS*LANES-1:0]      req_be;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            resp_valid;
  logic [DATA_LEN-1:0]             resp_data;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_be,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_be,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/multi_port_memory.sv
// Shared byte-addressed big-endian memory, one transaction in flight.
// Define MULTI_PORT_MEMORY_RR_ARB_EN for round-robin, else fixed priority.
module multi_port_memory #(
  parameter int ADDR_WIDTH = 20,
  parameter int BYTE_SIZE  = 8,
  parameter int LANES      = 4,
  parameter int NUM_PORTS  = 2,
  parameter int LATENCY    = 2
) (
  input  logic clk,
  input  logic rst_n,
  multi_port_memory_if.slave bus
);
  localparam int DATA_LEN = LANES * BYTE_SIZE;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [PW-1:0]         port;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_LEN-1:0]   wdata;
    logic [LANES-1:0]      be;
  } req_t;

  state_t                r_state;
  state_t                w_next;
  req_t                  r_req;
  req_t                  w_sel;
  logic [CW-1:0]         r_cnt;
  logic [NUM_PORTS-1:0]  r_resp_valid;
  logic [NUM_PORTS-1:0]  w_resp_valid;
  logic [DATA_LEN-1:0]   r_resp_data;
  logic [DATA_LEN-1:0]   w_rdata;
  logic [NUM_PORTS-1:0]  w_grant;
  logic [PW-1:0]         w_gidx;
  logic                  w_gany;
  logic                  w_accept;
  logic                  w_access;

  // 2-state storage: zero at start, untouched by reset
  bit [BYTE_SIZE-1:0] r_mem [2**ADDR_WIDTH];

`ifdef MULTI_PORT_MEMORY_RR_ARB_EN
  logic [PW-1:0] r_ptr;

  // winner = valid port at smallest distance after r_ptr
  always_comb begin
    int best;
    int d;
    w_gany = 1'b0;
    w_gidx = '0;
    best   = NUM_PORTS;
    d      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      d = i - int'(r_ptr);
      if (d < 0) d += NUM_PORTS;
      if (bus.req_valid[i] && d < best) begin
        best   = d;
        w_gany = 1'b1;
        w_gidx = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_gidx == PW'(NUM_PORTS - 1)) ?
               '0 : w_gidx + 1'b1;
    end
  end
`else
  always_comb begin
    w_gany = 1'b0;
    w_gidx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_gany = 1'b1;
        w_gidx = PW'(i);
      end
    end
  end
`endif

  assign w_accept = (r_state == IDLE) && w_gany;
  assign w_access = (r_state == BUSY) && (r_cnt == '0);

  always_comb begin
    w_grant      = '0;
    w_resp_valid = '0;
    w_sel        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_grant[i]      = w_accept && (w_gidx == PW'(i));
      w_resp_valid[i] = w_access && (r_req.port == PW'(i));
      if (w_gidx == PW'(i)) begin
        w_sel.port  = PW'(i);
        w_sel.write = bus.req_write[i];
        w_sel.addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel.wdata = bus.req_wdata[i*DATA_LEN +: DATA_LEN];
        w_sel.be    = bus.req_be[i*LANES +: LANES];
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int k = 0; k < LANES; k++) begin
      w_rdata[DATA_LEN-1-k*BYTE_SIZE -: BYTE_SIZE] =
        r_mem[r_req.addr + ADDR_WIDTH'(k)];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (r_cnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= w_resp_valid;
      if (w_accept) begin
        r_req <= w_sel;
        r_cnt <= CW'(LATENCY - 1);
      end else if (r_state == BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access && !r_req.write) begin
        r_resp_data <= w_rdata;
      end
    end
  end

  // reset forces IDLE, so an abandoned write never reaches this port
  always_ff @(posedge clk) begin
    if (w_access && r_req.write) begin
      for (int k = 0; k < LANES; k++) begin
        if (r_req.be[LANES-1-k]) begin
          r_mem[r_req.addr + ADDR_WIDTH'(k)] <=
            r_req.wdata[DATA_LEN-1-k*BYTE_SIZE -: BYTE_SIZE];
        end
      end
    end
  end

  assign bus.req_ready  = rst_n ? w_grant : '0;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;

endmodule

// File: tb/tb_multi_port_memory.sv
// Directed + randomized bench for multi_port_memory against a byte-map model.
// Expected arbitration order follows MULTI_PORT_MEMORY_RR_ARB_EN.
module tb_multi_port_memory;
  localparam int AW = 20;
  localparam int BS = 8;
  localparam int LN = 4;
  localparam int NP = 2;
  localparam int DL = LN * BS;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multi_port_memory_if #(
    .ADDR_WIDTH(AW), .BYTE_SIZE(BS),
    .LANES(LN), .NUM_PORTS(NP)
  ) a_if ();

  multi_port_memory_if #(
    .ADDR_WIDTH(AW), .BYTE_SIZE(BS),
    .LANES(LN), .NUM_PORTS(NP)
  ) b_if ();

  multi_port_memory #(
    .ADDR_WIDTH(AW), .BYTE_SIZE(BS), .LANES(LN),
    .NUM_PORTS(NP), .LATENCY(LAT_A)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));

  multi_port_memory #(
    .ADDR_WIDTH(AW), .BYTE_SIZE(BS), .LANES(LN),
    .NUM_PORTS(NP), .LATENCY(LAT_B)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  int checks = 0;
  int errors = 0;
  logic [7:0]  model [int];
  logic [31:0] exp_last = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [19:0] ad);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < LN; k++) begin
      int x;
      x = (int'(ad) + k) % (1 << AW);
      d = (d << 8) | (model.exists(x) ? 32'(model[x]) : 32'h0);
    end
    return d;
  endfunction

  function automatic void m_wr(input logic [19:0] ad,
                               input logic [31:0] wd,
                               input logic [3:0] be);
    for (int k = 0; k < LN; k++) begin
      if (be[LN-1-k])
        model[(int'(ad) + k) % (1 << AW)] = 8'(wd >> (8 * (LN-1-k)));
    end
  endfunction

  task automatic txn(input int p, input bit wr,
                     input logic [19:0] ad,
                     input logic [31:0] wd,
                     input logic [3:0] be,
                     input string tag);
    int n;
    @(negedge clk);
    a_if.req_write[p] = wr;
    a_if.req_addr[p*AW +: AW] = ad;
    a_if.req_wdata[p*DL +: DL] = wd;
    a_if.req_be[p*LN +: LN] = be;
    a_if.req_valid = '0;
    a_if.req_valid[p] = 1'b1;
    #1;
    chk({tag, ":ready"}, 64'(a_if.req_ready), 64'(1) << p);
    @(posedge clk);
    #1;
    a_if.req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_if.resp_valid == '0 && n < 12);
    chk({tag, ":lat"}, 64'(n), 64'(LAT_A + 1));
    chk({tag, ":rv"}, 64'(a_if.resp_valid), 64'(1) << p);
    if (wr) m_wr(ad, wd, be);
    else exp_last = m_rd(ad);
    chk({tag, ":data"}, 64'(a_if.resp_data), 64'(exp_last));
    @(negedge clk);
    chk({tag, ":pulse"}, 64'(a_if.resp_valid), 64'(0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gp[$];
    int gc[$];
    int exp_gp[4];
    int p;
    bit wr;
    bit saw;
    logic [19:0] ad;
    logic [12:0] obs_rdy, obs_rv, exp_rdy, exp_rv;

`ifdef MULTI_PORT_MEMORY_RR_ARB_EN
    exp_gp = '{0, 1, 0, 1};
`else
    exp_gp = '{0, 0, 0, 0};
`endif

    a_if.req_valid = '0; a_if.req_write = '0;
    a_if.req_addr = '0;  a_if.req_wdata = '0;
    a_if.req_be = '0;
    b_if.req_valid = '0; b_if.req_write = '0;
    b_if.req_addr = '0;  b_if.req_wdata = '0;
    b_if.req_be = '0;

    // reset with requests pending: no grant, outputs zero
    #2 rst_n = 1'b0;
    a_if.req_valid = '1;
    #1;
    chk("rst:ready", 64'(a_if.req_ready), 64'(0));
    chk("rst:rv", 64'(a_if.resp_valid), 64'(0));
    chk("rst:data", 64'(a_if.resp_data), 64'(0));
    repeat (2) @(negedge clk);
    a_if.req_valid = '0;
    rst_n = 1'b1;

    txn(0, 1'b1, 20'h00100, 32'hDEADBEEF, 4'hF, "w100");
    txn(0, 1'b0, 20'h00100, 32'h0, 4'h0, "r100");
    chk("r100:const", 64'(a_if.resp_data), 64'h0DEADBEEF);

    txn(1, 1'b1, 20'h00200, 32'h11223344, 4'hF, "w200");
    txn(0, 1'b1, 20'h00200, 32'h00AA0000, 4'b0100, "w200be");
    txn(1, 1'b0, 20'h00200, 32'h0, 4'h0, "r200");
    chk("r200:const", 64'(a_if.resp_data), 64'h11AA3344);

    txn(1, 1'b1, 20'h00204, 32'h99887766, 4'h0, "wbe0");
    txn(0, 1'b0, 20'h00204, 32'h0, 4'h0, "rbe0");

    txn(0, 1'b1, 20'hFFFFE, 32'hCAFEF00D, 4'hF, "wwrap");
    txn(1, 1'b0, 20'hFFFFE, 32'h0, 4'h0, "rwrap");
    chk("rwrap:const", 64'(a_if.resp_data), 64'hCAFEF00D);
    txn(0, 1'b0, 20'h00000, 32'h0, 4'h0, "rwrap0");
    chk("rwrap0:hi", 64'(a_if.resp_data[31:16]), 64'hF00D);

    for (int i = 0; i < 30; i++) begin
      p  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        ad = 20'hFFFFC + 20'($urandom_range(0, 3));
      else
        ad = 20'h00400 + 20'($urandom_range(0, 15));
      txn(p, wr, ad, $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    txn(0, 1'b1, 20'h00300, 32'h5A5A1234, 4'hF, "w300");

    // reset while a write to 0x300 sits in BUSY
    @(negedge clk);
    a_if.req_write[0] = 1'b1;
    a_if.req_addr[0 +: AW] = 20'h00300;
    a_if.req_wdata[0 +: DL] = 32'hFFFF0000;
    a_if.req_be[0 +: LN] = 4'hF;
    a_if.req_valid = 2'b01;
    @(posedge clk);
    #1;
    a_if.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort:ready", 64'(a_if.req_ready), 64'(0));
    chk("abort:rv", 64'(a_if.resp_valid), 64'(0));
    chk("abort:data", 64'(a_if.resp_data), 64'(0));
    exp_last = '0;
    saw = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw |= (a_if.resp_valid != '0);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      saw |= (a_if.resp_valid != '0);
    end
    chk("abort:noresp", 64'(saw), 64'(0));

    // arbitration: both ports valid continuously, fresh pointer
    @(negedge clk);
    a_if.req_write = '0;
    a_if.req_addr[0 +: AW] = 20'h00300;
    a_if.req_addr[AW +: AW] = 20'h00300;
    a_if.req_valid = '1;
    for (int c = 0; c < 40 && gp.size() < 4; c++) begin
      #1;
      if (a_if.req_ready != '0) begin
        chk("arb:onehot", 64'($onehot(a_if.req_ready)), 64'(1));
        gp.push_back(a_if.req_ready[1] ? 1 : 0);
        gc.push_back(c);
      end
      @(negedge clk);
    end
    a_if.req_valid = '0;
    chk("arb:count", 64'(gp.size()), 64'(4));
    for (int i = 0; i < gp.size(); i++) begin
      chk($sformatf("arb:port%0d", i), 64'(gp[i]), 64'(exp_gp[i]));
      chk($sformatf("arb:gap%0d", i), 64'(gc[i] - gc[0]),
          64'(i * (LAT_A + 2)));
    end
    repeat (6) @(negedge clk);
    chk("arb:data", 64'(a_if.resp_data), 64'(m_rd(20'h00300)));

    txn(1, 1'b0, 20'h00300, 32'h0, 4'h0, "r300");
    chk("r300:const", 64'(a_if.resp_data), 64'h5A5A1234);

    // LATENCY=1 instance: back-to-back reads on port 1
    @(negedge clk);
    b_if.req_write = '0;
    b_if.req_addr[AW +: AW] = 20'h00040;
    b_if.req_valid = 2'b10;
    for (int c = 0; c < 13; c++) begin
      #1;
      obs_rdy[c] = b_if.req_ready[1];
      obs_rv[c]  = b_if.resp_valid[1];
      exp_rdy[c] = (c % 3) == 0;
      exp_rv[c]  = (c % 3) == 2;
      @(negedge clk);
    end
    b_if.req_valid = '0;
    chk("b:ready", 64'(obs_rdy), 64'(exp_rdy));
    chk("b:rv", 64'(obs_rv), 64'(exp_rv));
    chk("b:data", 64'(b_if.resp_data), 64'(0));
    chk("b:p0", 64'(b_if.resp_valid[0]), 64'(0));

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_port_memory.md
MULTI_PORT_MEMORY -- requirements
Module: multi_port_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, meaning byte address width (storage = 2**ADDR_WIDTH bytes).
REQ-002 SHALL have parameter BYTE_SIZE, default 8, meaning bits per byte.
REQ-003 SHALL have parameter LANES, default 4, meaning bytes per beat (DATA_LEN = LANES*BYTE_SIZE).
REQ-004 SHALL have parameter NUM_PORTS, default 2, meaning requester count (port 0 = data cache, port 1 = instruction cache).
REQ-005 SHALL have parameter LATENCY, default 2, meaning cycles from grant to response, minimum 1.
REQ-006 SHALL have port clk, input, 1, meaning sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port req_valid, input, NUM_PORTS, meaning per-port request pending.
REQ-009 SHALL have port req_write, input, NUM_PORTS, meaning 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, NUM_PORTS*ADDR_WIDTH, meaning packed byte addresses, port i at slice i.
REQ-011 SHALL have port req_wdata, input, NUM_PORTS*DATA_LEN, meaning packed write data.
REQ-012 SHALL have port req_be, input, NUM_PORTS*LANES, meaning packed byte enables, bit LANES-1 = lowest address.
REQ-013 SHALL have port req_ready, output, NUM_PORTS, meaning one-hot grant; the request is accepted when req_valid&req_ready.
REQ-014 SHALL have port resp_valid, output, NUM_PORTS, meaning one-cycle completion pulse to the granted port.
REQ-015 SHALL have port resp_data, output, DATA_LEN, meaning read data, shared by all ports.

Function
REQ-016 SHALL use big-endian lane order: byte at addr+k maps to resp_data/req_wdata bits [DATA_LEN-1-k*BYTE_SIZE -: BYTE_SIZE].
REQ-017 SHALL run FSM IDLE -> BUSY -> RESP -> IDLE, with one transaction in flight.
REQ-018 SHALL in IDLE assert req_ready combinationally to the arbitration winner among req_valid; all zero when none valid; no grant in BUSY or RESP.
REQ-019 SHALL on acceptance latch port id, write flag, address, data and byte enables, load counter with LATENCY-1, and go to BUSY.
REQ-020 SHALL in BUSY decrement the counter each cycle and go to RESP when the counter is zero.
REQ-021 SHALL at RESP entry perform the storage access: write enabled bytes only, or read all LANES bytes into resp_data.
REQ-022 SHALL in RESP pulse resp_valid[port] for exactly one cycle, then return to IDLE; grant is possible again the following cycle.
REQ-023 SHALL hold resp_data stable until the next read completes; writes leave it unchanged.
REQ-024 SHALL wrap byte addresses modulo 2**ADDR_WIDTH (address all-ones + 1 -> 0).
REQ-025 SHALL treat a write with req_be all zero as a legal no-op that still returns resp_valid.
REQ-026 SHALL in fixed-priority mode grant the lowest-index valid port.

Reset
REQ-027 SHALL on rst_n low immediately force FSM to IDLE, counter 0, req_ready 0, resp_valid 0, resp_data 0, and round-robin pointer to port 0.
REQ-028 SHALL abandon an in-flight transaction on reset, with no storage write and no resp_valid.
REQ-029 SHALL NOT clear storage on reset; storage SHALL be zero at simulation start.

Configuration
REQ-030 SHALL, when MULTI_PORT_MEMORY_RR_ARB_EN is defined, use round-robin arbitration: search starts at the port after the last granted port.
REQ-031 SHALL, when MULTI_PORT_MEMORY_RR_ARB_EN is undefined, use fixed priority per REQ-026 with no pointer register.

Verification
REQ-032 SHALL cover: port 0 write addr 0x100 data 0xDEADBEEF be 0xF, then read 0x100 -> resp_data 0xDEADBEEF, resp_valid[0] LATENCY+1 cycles after grant.
REQ-033 SHALL cover: word 0x11223344 at 0x200, write be 0b0100 data 0x00AA0000 -> read returns 0x11AA3344.
REQ-034 SHALL cover: both ports valid every cycle for 4 grants -> fixed: all to port 0; RR: 0,1,0,1.
REQ-035 SHALL cover: write 0xCAFEF00D at 0xFFFFE (ADDR_WIDTH 20) -> bytes at 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
REQ-036 SHALL cover: rst_n low during BUSY of a write to 0x300 -> no resp_valid, and read of 0x300 returns the prior value.
REQ-037 SHALL cover: LATENCY=1, back-to-back reads on port 1 -> grant every 3 cycles, resp_valid one cycle wide each.
